// File: rtl/enemy_missile_dispatcher.sv
// ---------------------------------------------------------------------------
// enemy_missile_dispatcher
//
// Paces enemy missile launches for one attack wave. After wave_start, a
// frame-tick interval counter spaces the launches. Each launch takes the
// lowest free missile slot and a target index taken from target_sel. Once the
// last missile of the wave has been handed to the engine, the block waits
// until every slot has been released. It then pulses wave_done and returns to
// IDLE.
//
// Parameters
//   SPAWN_FRAMES  frame ticks between launches within a wave (1..255)
//   WAVE_SIZE     missiles per wave (1..31)
//
// Ports
//   clk            system clock; all state changes on its rising edge
//   rst_n          asynchronous active-low reset
//   target_sel     raw target index; sampled only while picking a launch
//   frame_tick     one-cycle pulse per video frame
//   wave_start     one-cycle pulse; starts a wave when idle, ignored otherwise
//   missile_dead   per-slot pulse; the missile in that slot has ended
//   launch_ready   missile engine accepts the pending launch
//   launch_valid   launch request pending
//   launch_slot    slot of the pending launch
//   launch_target  target (0..2) of the pending launch
//   busy           slot occupancy mask
//   missiles_left  launches still to be made in this wave
//   active         high whenever the dispatcher is not idle
//   wave_done      one-cycle pulse when the wave has fully completed
//
// Build option
//   DISPATCH_SKIP_REPEAT_EN  when defined, a pick that maps to the target of
//                            the previous launch is resampled on the next
//                            clock. Up to three resamples in a row are made.
//                            The fourth sample is always taken.
// ---------------------------------------------------------------------------
module enemy_missile_dispatcher #(
    parameter int SPAWN_FRAMES = 60,
    parameter int WAVE_SIZE    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] target_sel,
    input  logic       frame_tick,
    input  logic       wave_start,
    input  logic [3:0] missile_dead,
    input  logic       launch_ready,
    output logic       launch_valid,
    output logic [1:0] launch_slot,
    output logic [1:0] launch_target,
    output logic [3:0] busy,
    output logic [4:0] missiles_left,
    output logic       active,
    output logic       wave_done
);

    localparam logic [7:0] SPAWN_RELOAD = 8'(SPAWN_FRAMES);
    localparam logic [4:0] WAVE_RELOAD  = 5'(WAVE_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_PICK   = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // Only three targets exist; out-of-range selector values fold onto the last one.
    function automatic logic [1:0] map_target(input logic [2:0] sel);
        if (sel > 3'd2) begin
            return 2'd2;
        end else begin
            return sel[1:0];
        end
    endfunction

    // Lowest-index clear bit of the occupancy mask (callers ensure one exists).
    function automatic logic [1:0] lowest_free(input logic [3:0] occ);
        if (!occ[0]) begin
            return 2'd0;
        end else if (!occ[1]) begin
            return 2'd1;
        end else if (!occ[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    function automatic logic [3:0] slot_mask(input logic [1:0] slot);
        return 4'b0001 << slot;
    endfunction

    state_t     state_r, state_s;
    logic [7:0] interval_r, interval_s;
    logic [4:0] left_r, left_s;
    logic [3:0] busy_r, busy_s;
    logic [1:0] slot_r, slot_s;
    logic [1:0] target_r, target_s;
    logic       valid_r;
    logic       active_r;
    logic       done_r, done_s;
    logic       handshake_s;
    logic [1:0] pick_target_s;
`ifdef DISPATCH_SKIP_REPEAT_EN
    logic [1:0] last_target_r, last_target_s;
    logic [1:0] repeat_cnt_r, repeat_cnt_s;
`endif

    // Next-state, counters and slot bookkeeping for the wave sequencer.
    always_comb begin
        state_s       = state_r;
        interval_s    = interval_r;
        left_s        = left_r;
        slot_s        = slot_r;
        target_s      = target_r;
        done_s        = 1'b0;
        handshake_s   = valid_r & launch_ready;
        pick_target_s = map_target(target_sel);
        // Releases apply in every state; a handshake below ORs its slot back in,
        // so a same-clock launch into a slot that is also being released keeps it busy.
        busy_s        = busy_r & ~missile_dead;
`ifdef DISPATCH_SKIP_REPEAT_EN
        last_target_s = last_target_r;
        repeat_cnt_s  = repeat_cnt_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (wave_start) begin
                    state_s    = ST_WAIT;
                    left_s     = WAVE_RELOAD;
                    interval_s = SPAWN_RELOAD;
                end else begin
                    state_s    = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (interval_r == 8'd0) begin
                    // The counter stays at zero until a slot frees up.
                    if (busy_r != 4'b1111) begin
                        state_s = ST_PICK;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else if (frame_tick) begin
                    interval_s = interval_r - 8'd1;
                end else begin
                    interval_s = interval_r;
                end
            end

            ST_PICK: begin
                slot_s   = lowest_free(busy_r);
                target_s = pick_target_s;
`ifdef DISPATCH_SKIP_REPEAT_EN
                if ((pick_target_s == last_target_r) && (repeat_cnt_r != 2'd3)) begin
                    state_s      = ST_PICK;
                    repeat_cnt_s = repeat_cnt_r + 2'd1;
                end else begin
                    state_s      = ST_LAUNCH;
                    repeat_cnt_s = 2'd0;
                end
`else
                state_s  = ST_LAUNCH;
`endif
            end

            ST_LAUNCH: begin
                if (handshake_s) begin
                    busy_s     = busy_s | slot_mask(slot_r);
                    left_s     = left_r - 5'd1;
                    interval_s = SPAWN_RELOAD;
`ifdef DISPATCH_SKIP_REPEAT_EN
                    last_target_s = target_r;
`endif
                    if (left_r <= 5'd1) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_LAUNCH;
                end
            end

            ST_DRAIN: begin
                if (busy_r == 4'b0000) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are derived from next-state values so they are all flopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            interval_r <= 8'd0;
            left_r     <= 5'd0;
            busy_r     <= 4'b0000;
            slot_r     <= 2'd0;
            target_r   <= 2'd0;
            valid_r    <= 1'b0;
            active_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            interval_r <= interval_s;
            left_r     <= left_s;
            busy_r     <= busy_s;
            slot_r     <= slot_s;
            target_r   <= target_s;
            valid_r    <= (state_s == ST_LAUNCH);
            active_r   <= (state_s != ST_IDLE);
            done_r     <= done_s;
        end
    end

`ifdef DISPATCH_SKIP_REPEAT_EN
    // Repeat-avoidance history; 3 matches no real target, so the first launch is never resampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_target_r <= 2'd3;
            repeat_cnt_r  <= 2'd0;
        end else begin
            last_target_r <= last_target_s;
            repeat_cnt_r  <= repeat_cnt_s;
        end
    end
`endif

    assign launch_valid  = valid_r;
    assign launch_slot   = slot_r;
    assign launch_target = target_r;
    assign busy          = busy_r;
    assign missiles_left = left_r;
    assign active        = active_r;
    assign wave_done     = done_r;

endmodule
